// File: rtl/dual_issue_dispatch_ctrl.sv
`default_nettype none
// ==== dual_issue_dispatch_ctrl : two-wide queue sequencer and in-order dispatcher | rev 1.0 ====
module dual_issue_dispatch_ctrl #(
  parameter int CNT_W  = 3,
  parameter int STAT_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       inst_in1,
  input  logic [31:0]       inst_in2,
  input  logic              valid_in1,
  input  logic              valid_in2,
  input  logic              queue_empty,
  input  logic [CNT_W-1:0]  alu_rs_free,
  input  logic [CNT_W-1:0]  mul_rs_free,
  input  logic [CNT_W-1:0]  lsu_rs_free,
  input  logic [CNT_W-1:0]  rob_free,
  output logic              queue_advance,
  output logic              disp_valid1,
  output logic [31:0]       disp_inst1,
  output logic [1:0]        disp_unit1,
  output logic              disp_valid2,
  output logic [31:0]       disp_inst2,
  output logic [1:0]        disp_unit2,
  output logic              dispatch_done,
  output logic              illegal_seen,
  output logic [STAT_W-1:0] dispatched_count,
  output logic [STAT_W-1:0] nop_count,
  output logic [STAT_W-1:0] stall_cycles
);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_CAPTURE, S_ISSUE, S_DONE} state_e;
  typedef enum logic [2:0] {K_NOP, K_ALU, K_MUL, K_LSU, K_ILL} kind_e;

  function automatic kind_e decode(input logic [31:0] inst);
    kind_e k;
    k = K_ILL;
    if (inst == 32'h0000_0013) begin
      k = K_NOP;
    end else begin
      case (inst[6:0])
        7'b0110011:             k = (inst[31:25] == 7'b0000001) ? K_MUL : K_ALU;
        7'b0010011:             k = K_ALU;
        7'b0000011, 7'b0100011: k = K_LSU;
        default:                k = K_ILL;
      endcase
    end
    return k;
  endfunction

  function automatic logic [1:0] unit_of(input kind_e k);
    logic [1:0] u;
    case (k)
      K_MUL:   u = 2'd1;
      K_LSU:   u = 2'd2;
      default: u = 2'd0;
    endcase
    return u;
  endfunction

  function automatic logic [STAT_W-1:0] sat_add(input logic [STAT_W-1:0] a, input logic [1:0] inc);
    logic [STAT_W:0] s;
    s = {1'b0, a} + {{(STAT_W-1){1'b0}}, inc};
    return s[STAT_W] ? '1 : s[STAT_W-1:0];
  endfunction

  state_e             state_q;
  logic [31:0]        entry0_q, entry1_q;
  logic               v0_q, v1_q;
  logic               illegal_q;
  logic [STAT_W-1:0]  dispatched_q, nop_q, stall_q;
  logic [STAT_W-1:0]  dispatched_d, nop_d, stall_d;

  kind_e              kind0, kind1;
  logic [CNT_W-1:0]   free0, free1;
  logic [CNT_W:0]     rob_need, unit_need;
  logic               issuing, sq0, dp0, go0, sq1, dp1, go1;

  always_comb begin
    kind0 = decode(entry0_q);
    kind1 = decode(entry1_q);
    case (kind0)
      K_MUL:   free0 = mul_rs_free;
      K_LSU:   free0 = lsu_rs_free;
      default: free0 = alu_rs_free;
    endcase
    case (kind1)
      K_MUL:   free1 = mul_rs_free;
      K_LSU:   free1 = lsu_rs_free;
      default: free1 = alu_rs_free;
    endcase
    issuing = (state_q == S_ISSUE);
    sq0 = issuing && v0_q && (kind0 == K_NOP || kind0 == K_ILL);
    dp0 = issuing && v0_q && !sq0 && (free0 != '0) && (rob_free != '0);
    go0 = sq0 || dp0;
    // The younger entry competes for whatever the head already consumed this cycle.
    rob_need  = dp0 ? (CNT_W+1)'(2) : (CNT_W+1)'(1);
    unit_need = (dp0 && kind0 == kind1) ? (CNT_W+1)'(2) : (CNT_W+1)'(1);
    sq1 = go0 && v1_q && (kind1 == K_NOP || kind1 == K_ILL);
    dp1 = go0 && v1_q && !sq1 && ({1'b0, rob_free} >= rob_need) && ({1'b0, free1} >= unit_need);
    go1 = sq1 || dp1;

    dispatched_d = sat_add(dispatched_q, {1'b0, dp0} + {1'b0, dp1});
    nop_d        = sat_add(nop_q, {1'b0, sq0} + {1'b0, sq1});
    stall_d      = sat_add(stall_q, {1'b0, issuing && v0_q && !go0});
  end

  assign queue_advance    = (state_q == S_FETCH);
  assign dispatch_done    = (state_q == S_DONE);
  assign illegal_seen     = illegal_q;
  assign dispatched_count = dispatched_q;
  assign nop_count        = nop_q;
  assign stall_cycles     = stall_q;

  // A squashed head hands port 1 to the younger entry.
  assign disp_valid1 = dp0 || dp1;
  assign disp_inst1  = dp0 ? entry0_q : (dp1 ? entry1_q : 32'd0);
  assign disp_unit1  = dp0 ? unit_of(kind0) : (dp1 ? unit_of(kind1) : 2'd0);
  assign disp_valid2 = dp0 && dp1;
  assign disp_inst2  = (dp0 && dp1) ? entry1_q : 32'd0;
  assign disp_unit2  = (dp0 && dp1) ? unit_of(kind1) : 2'd0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      entry0_q     <= '0;
      entry1_q     <= '0;
      v0_q         <= 1'b0;
      v1_q         <= 1'b0;
      illegal_q    <= 1'b0;
      dispatched_q <= '0;
      nop_q        <= '0;
      stall_q      <= '0;
    end else begin
      dispatched_q <= dispatched_d;
      nop_q        <= nop_d;
      stall_q      <= stall_d;
      case (state_q)
        S_IDLE:  state_q <= S_FETCH;
        S_FETCH: state_q <= S_CAPTURE;
        S_CAPTURE: begin
          if (!valid_in1 && queue_empty) begin
            state_q <= S_DONE;
          end else begin
            // A lone valid slot 2 is compacted into the head so the buffer never has a hole.
            if (valid_in1) begin
              entry0_q <= inst_in1;
              v0_q     <= 1'b1;
              entry1_q <= inst_in2;
              v1_q     <= valid_in2;
            end else begin
              entry0_q <= inst_in2;
              v0_q     <= valid_in2;
              entry1_q <= '0;
              v1_q     <= 1'b0;
            end
            if ((valid_in1 && decode(inst_in1) == K_ILL) || (valid_in2 && decode(inst_in2) == K_ILL))
              illegal_q <= 1'b1;
            state_q <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (!v0_q) begin
            state_q <= S_FETCH;
          end else if (go0) begin
            if (go1 || !v1_q) begin
              v0_q    <= 1'b0;
              v1_q    <= 1'b0;
              state_q <= S_FETCH;
            end else begin
              entry0_q <= entry1_q;
              v0_q     <= v1_q;
              v1_q     <= 1'b0;
            end
          end
        end
        S_DONE:  state_q <= S_DONE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/dual_issue_dispatch_ctrl.md
Name: dual_issue_dispatch_ctrl

Overview:
- Sequences the two-wide instruction queue for the superscalar out-of-order core.
- Drives queue_advance and captures each delivered instruction pair into a 2-entry in-order hold buffer.
- Decodes each instruction to a functional-unit class (ALU / MUL / LSU) and dispatches up to two per cycle, subject to reservation-station and ROB free counts.
- Squashes NOPs, collects dispatch/stall statistics, and signals completion once the queue reports empty.

Parameters:
CNT_W, 3, width of every free-count input (max 2**CNT_W-1 free slots)
STAT_W, 16, width of statistic counters (saturating)

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-high reset
inst_in1  input  32  queue slot 1 instruction (older)
inst_in2  input  32  queue slot 2 instruction (younger)
valid_in1  input  1  slot 1 valid
valid_in2  input  1  slot 2 valid
queue_empty  input  1  queue exhausted
alu_rs_free  input  CNT_W  free ALU reservation-station entries
mul_rs_free  input  CNT_W  free MUL reservation-station entries
lsu_rs_free  input  CNT_W  free LSU reservation-station entries
rob_free  input  CNT_W  free ROB entries
queue_advance  output  1  request next pair from queue
disp_valid1  output  1  dispatch port 1 valid (older)
disp_inst1  output  32  dispatch port 1 instruction
disp_unit1  output  2  port 1 unit: 0 ALU, 1 MUL, 2 LSU
disp_valid2  output  1  dispatch port 2 valid
disp_inst2  output  32  dispatch port 2 instruction
disp_unit2  output  2  port 2 unit
dispatch_done  output  1  all instructions consumed (sticky)
illegal_seen  output  1  sticky: unknown opcode captured
dispatched_count  output  STAT_W  total instructions dispatched
nop_count  output  STAT_W  total NOPs and illegals squashed
stall_cycles  output  STAT_W  ISSUE cycles with no forward progress

Behaviour:
- Reset (async, active-high):
  - state=IDLE; buffer entries invalid.
  - All counters=0; dispatch_done=0; illegal_seen=0.
  - queue_advance=0; disp_valid1/2=0; disp_inst1/2=0; disp_unit1/2=0.
  - Reset mid-operation aborts everything; any pair in flight is discarded.
- Decode, opcode = inst[6:0]:
  - 0x00000013 exactly = NOP.
  - 0110011 with inst[31:25]=0000001 = MUL; any other 0110011 = ALU.
  - 0010011 (other than NOP) = ALU.
  - 0000011 or 0100011 = LSU.
  - Anything else = illegal: squashed like a NOP, sets illegal_seen.
- FSM states:
  - IDLE: one cycle, then FETCH.
  - FETCH: queue_advance=1 (combinational, this state only) -> CAPTURE.
  - CAPTURE: queue outputs are updated by now.
    - If valid_in1=0 and queue_empty=1: go to DONE.
    - Otherwise load entry0<=inst_in1 (valid_in1) and entry1<=inst_in2 (valid_in2), then go to ISSUE.
  - ISSUE: dispatch/squash from the buffer. When the buffer is empty after this edge -> FETCH.
  - DONE: dispatch_done=1, terminal until reset.
- Issue rules (ISSUE state; free counts sampled this cycle; combinational disp outputs):
  - Strict program order: entry1 never leaves before entry0.
  - NOP/illegal at the head is removed without using a dispatch port or any resources. nop_count increments by 1 per removal.
  - Head entry dispatches on port 1 if its unit free>=1 and rob_free>=1.
  - Entry1 may leave in the same cycle only if the head also left. Then:
    - If entry1 is NOP/illegal, it is squashed.
    - Otherwise it dispatches on port 2 (port 1 if the head was squashed). It needs rob_free >= dispatches so far + 1, and its unit free >= same-unit dispatches so far + 1.
  - Entry1 alone remaining shifts to entry0 at the edge.
  - No entry leaves and buffer non-empty: stall_cycles++.
  - dispatched_count increments by the number of disp_valid asserted.
  - disp_valid2 is never asserted without disp_valid1.
- Counters saturate at all-ones.
- Throughput: best case one pair per 3 cycles (FETCH, CAPTURE, ISSUE).

Test Plan:
- Reset, all free counts=4, pair ADD(0x00208033-class),MUL -> ISSUE cycle: disp_valid1/2=1, units 0/1, dispatched_count=2, next state FETCH.
- Pair ADD,NOP with free counts=4 -> only disp_valid1=1 unit 0, NOP squashed same cycle, nop_count=1.
- Pair LOAD,STORE, lsu_rs_free=1 -> LOAD dispatches on port 1; STORE shifts to head. Hold lsu_rs_free=0 two cycles -> stall_cycles=2. Raise to 1 -> STORE dispatches.
- Pair MUL,MUL with rob_free=0 for 3 cycles then 2 -> stall_cycles=3, then both dispatch in one cycle.
- Pair with opcode 1111111 in slot 1 -> illegal_seen=1, nop_count++, slot 2 still dispatched.
- Run all 20 queued instructions, free counts=7 -> dispatched_count=14, nop_count=6, dispatch_done=1. Assert reset mid-run -> all outputs return to reset values immediately.
